// File: rtl/cmd_queue_pkg.sv
// cmd_queue_pkg: system-wide sizing defines and the command word shared by loader, queue and issuer.
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif
`ifndef BUS_W
`define BUS_W 16
`endif
`ifndef CMDQ_DEPTH
`define CMDQ_DEPTH 16
`endif

package cmd_queue_pkg;
  typedef struct packed {
    logic [3:0]                      op;
    logic [$clog2(`PROC_COUNT)-1:0]  proc;
    logic [`BUS_W-1:0]               addr;
  } cmd_t;
endpackage

// File: rtl/cmdq_mem.sv
// cmdq_mem: DEPTH x CMD_W register array, one write port and one asynchronous read port.
module cmdq_mem #(
  parameter int DEPTH = 16,
  parameter int CMD_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [CMD_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [CMD_W-1:0]         rdata
);
  logic [CMD_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/cmd_queue.sv
// cmd_queue: FWFT command FIFO feeding the issuer, with occupancy, almost-full, flush and sticky error flags.
import cmd_queue_pkg::*;

module cmd_queue #(
  parameter int DEPTH    = `CMDQ_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int CMD_W    = $bits(cmd_t)
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_flush,
  input  logic                     i_wr,
  input  logic [CMD_W-1:0]         i_cmd,
  output logic                     o_full,
  output logic                     o_almost_full,
  input  logic                     i_rd,
  output logic [CMD_W-1:0]         o_cmd,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [AW:0] AF = PW'(AF_LEVEL);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic        ovf_q, ovf_d, unf_q, unf_d;
  logic        wr_ok, rd_ok;
  // Status comes from state only so the issuer's pop strobe never loops back combinationally.
  assign o_empty       = wr_ptr_q == rd_ptr_q;
  assign o_full        = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign o_almost_full = count_q >= AF;
  assign o_count       = count_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;
  assign rd_ok = i_rd & ~o_empty;
  assign wr_ok = i_wr & (~o_full | rd_ok);
  always_comb begin
    wr_ptr_d = i_flush ? '0 : wr_ptr_q + PW'(wr_ok);
    rd_ptr_d = i_flush ? '0 : rd_ptr_q + PW'(rd_ok);
    count_d  = i_flush ? '0 : count_q + PW'(wr_ok) - PW'(rd_ok);
    ovf_d    = ~i_flush & (ovf_q | (i_wr & ~wr_ok));
    unf_d    = ~i_flush & (unf_q | (i_rd & ~rd_ok));
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  cmdq_mem #(.DEPTH(DEPTH), .CMD_W(CMD_W)) u_mem (
    .clk   (i_clk),
    .we    (wr_ok & ~i_flush & i_rstn),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (i_cmd),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (o_cmd)
  );
endmodule

// File: doc/cmd_queue.md
Name: cmd_queue

Overview:
- Synchronous command FIFO directly upstream of the issuer.
- Buffers cmd_t words written by the host/loader and presents them first-word-fall-through (FWFT) on the issuer's i_cmd / i_empty_queue / o_rd_queue interface.
- Adds occupancy, almost-full back-pressure, flush and sticky error flags.

Parameters:
- DEPTH, 16, number of cmd_t entries; power of two, at least 2.
- AF_LEVEL, DEPTH-2, o_almost_full asserts when occupancy is at least AF_LEVEL.
- CMD_W, $bits(cmd_t), width of one stored command.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rstn  in  1  reset; synchronous, active-low.
- i_flush  in  1  synchronous clear of queue contents and error flags.
- i_wr  in  1  write strobe from producer.
- i_cmd  in  CMD_W  command to enqueue; sampled when i_wr=1.
- o_full  out  1  occupancy equals DEPTH.
- o_almost_full  out  1  occupancy is at least AF_LEVEL.
- i_rd  in  1  pop strobe; driven by the issuer's o_rd_queue.
- o_cmd  out  CMD_W  head entry (FWFT); drives the issuer's i_cmd.
- o_empty  out  1  occupancy is 0; drives the issuer's i_empty_queue.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_overflow  out  1  sticky: write attempted while full with no pop in the same cycle.
- o_underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (i_rstn=0 at posedge):
  - wr_ptr, rd_ptr and count cleared.
  - o_empty=1, o_full=0, o_almost_full=0 (AF_LEVEL is at least 1).
  - o_count=0, o_overflow=0, o_underflow=0.
  - Storage contents are not cleared. o_cmd is don't-care while o_empty=1.
- Reset mid-operation discards all entries. Any i_wr/i_rd in the reset cycle is ignored.
- Pointers: $clog2(DEPTH)+1 bits each; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when only the MSBs differ.
  - Index wraps from DEPTH-1 to 0 naturally.
- Write acceptance: wr_ok = i_wr & (~o_full | rd_ok).
  - Writing while full is allowed only when a pop happens in the same cycle.
  - On wr_ok: mem[wr_ptr] <= i_cmd, wr_ptr++.
- Read acceptance: rd_ok = i_rd & ~o_empty.
  - On rd_ok: rd_ptr++.
  - o_cmd shows the new head in the following cycle.
- o_cmd = mem[rd_ptr[idx]], driven combinationally from storage (FWFT).
  - Write-to-visible latency: 1 cycle. A command written at edge N appears on o_cmd, with o_empty=0, after edge N.
- Simultaneous events:
  - wr_ok and rd_ok together: count unchanged, both pointers advance.
  - Empty with i_wr and i_rd together: the read is rejected (underflow flagged) and the write is accepted. There is no same-cycle bypass.
- Error flags:
  - Rejected write sets o_overflow. Data is dropped and the queue is unchanged.
  - Rejected read sets o_underflow. Pointers are unchanged.
  - Both flags are sticky until reset or flush.
- Flush:
  - Same effect as reset on pointers, count and flags.
  - Takes priority over i_wr/i_rd in the same cycle; neither is accepted.
- Status outputs (o_full, o_empty, o_almost_full) are registered/derived from state only, never from i_wr/i_rd. This avoids a combinational loop with the issuer's o_rd_queue.
- o_count updates in the same edge as the pointers. Its range is 0..DEPTH.

Decomposition:
- Shared package: cmd_t (existing command struct), plus a new `CMDQ_DEPTH define alongside `PROC_COUNT / `BUS_W.
- One natural sub-module: cmdq_mem, a DEPTH x CMD_W register array.
  - One write port, one asynchronous read port.
  - Keeps the storage swappable for a RAM macro later.
- Pointer, count and flag logic stays in cmd_queue.
- Top integration: cmd_queue.o_cmd feeds queue_cmd, cmd_queue.o_empty feeds queue_empty, and issuer_rd_queue drives i_rd.

Test Plan:
- Reset check: hold i_rstn=0 for 2 cycles with i_wr=1 -> o_empty=1, o_count=0, o_full=0, both error flags 0.
- FWFT order, DEPTH=16: write cmds 0x1..0x3 on consecutive cycles -> o_cmd=0x1 one cycle after the first write; pop 3 times -> o_cmd sequence 0x1, 0x2, 0x3, then o_empty=1 and o_count=0.
- Fill and overflow: write 16 entries -> o_almost_full=1 at count 14, o_full=1 at count 16; a 17th write with i_rd=0 -> o_overflow=1, o_count stays 16, head unchanged.
- Full with simultaneous read/write: at count 16, pulse i_wr=1 and i_rd=1 -> o_count stays 16, o_overflow stays 0; the new cmd is read out last after wrap-around (verifies pointer wrap).
- Empty with simultaneous read/write: at count 0, pulse i_wr=1 (cmd 0xA) and i_rd=1 -> o_underflow=1, o_count=1, o_cmd=0xA next cycle.
- Flush priority: at count 5 with o_overflow=1, assert i_flush together with i_wr -> next cycle o_count=0, o_empty=1, o_overflow=0, write discarded.
